// File: rtl/pwm_uart_multi.sv
// Multi-channel PWM dimmer driven by up/down buttons and UART level commands, with per-channel status reports.
// Build option: define PWM_UART_RAMP_EN to ramp current toward target one level per STEP_TICKS cycles.
module pwm_uart_multi #(
  parameter int CHANNELS   = 2,
  parameter int LEVEL_W    = 3,
  parameter int PWM_PERIOD = 27000,
  parameter int STEP_TICKS = 2700000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] up,
  input  logic [CHANNELS-1:0] down,
  input  logic [7:0]          cmd_byte,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  output logic [7:0]          status_byte,
  output logic                status_valid,
  input  logic                status_ready,
  output logic                cmd_error,
  output logic [CHANNELS-1:0] pwm
);
  // The command and status bytes carry a 3-bit level field, so LEVEL_W is at most 3.
  localparam logic [LEVEL_W-1:0] MAXL     = '1;
  localparam int                 UNIT     = PWM_PERIOD / ((1 << LEVEL_W) - 1);
  localparam int                 DW       = $clog2(PWM_PERIOD + 1);
  localparam logic [DW-1:0]      PWM_LAST = DW'(PWM_PERIOD - 1);
  localparam logic [4:0]         CH_LIM   = 5'(CHANNELS);

  logic [LEVEL_W-1:0]  target   [CHANNELS];
  logic [LEVEL_W-1:0]  current  [CHANNELS];
  logic [LEVEL_W-1:0]  duty_lvl [CHANNELS];
  logic [DW-1:0]       duty     [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] pend_set;
  logic [CHANNELS-1:0] pend_clr;
  logic [DW-1:0]       pwm_cnt;
  logic                pwm_wrap;

  logic [3:0]          cmd_ch;
  logic [LEVEL_W-1:0]  cmd_lvl;
  logic                cmd_take;
  logic                cmd_good;

  logic                rpt_hit;
  logic [3:0]          rpt_ch;
  logic [LEVEL_W-1:0]  rpt_lvl;
  logic [2:0]          rpt_lvl3;

  assign cmd_ch    = cmd_byte[7:4];
  assign cmd_lvl   = cmd_byte[LEVEL_W-1:0];
  assign cmd_ready = ~(|pending) | ~status_valid;
  assign cmd_take  = cmd_valid & cmd_ready;
  assign cmd_good  = cmd_take & ~cmd_byte[3] & ({1'b0, cmd_ch} < CH_LIM);
  assign pwm_wrap  = (pwm_cnt == PWM_LAST);

  // Descending scan so the lowest eligible channel is the one left selected.
  always_comb begin
    rpt_hit  = 1'b0;
    rpt_ch   = '0;
    rpt_lvl  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i] && (current[i] == target[i])) begin
        rpt_hit = 1'b1;
        rpt_ch  = 4'(i);
        rpt_lvl = current[i];
      end
    end
    rpt_lvl3 = '0;
    rpt_lvl3[LEVEL_W-1:0] = rpt_lvl;
    pend_set = '0;
    pend_clr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pend_set[i] = cmd_good && (cmd_ch == 4'(i));
      pend_clr[i] = !status_valid && rpt_hit && (rpt_ch == 4'(i));
    end
  end

`ifdef PWM_UART_RAMP_EN
  localparam int            TW        = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
  logic [TW-1:0] tick_cnt;
  logic          step_now;

  assign step_now = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (step_now) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (pwm_wrap) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        target[i]   <= '0;
        current[i]  <= '0;
        duty_lvl[i] <= '0;
        duty[i]     <= '0;
      end
      pending <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // A command to this channel overrides any button press in the same cycle.
        if (cmd_good && (cmd_ch == 4'(i))) begin
          target[i] <= cmd_lvl;
        end else if (up[i] && !down[i]) begin
          if (target[i] != MAXL) target[i] <= target[i] + LEVEL_W'(1);
        end else if (down[i] && !up[i]) begin
          if (target[i] != '0) target[i] <= target[i] - LEVEL_W'(1);
        end
`ifdef PWM_UART_RAMP_EN
        if (step_now && (current[i] != target[i])) begin
          current[i] <= (current[i] < target[i]) ? current[i] + LEVEL_W'(1)
                                                 : current[i] - LEVEL_W'(1);
        end
`else
        current[i] <= target[i];
`endif
        // Duty only changes at the period boundary so no output pulse is ever clipped.
        if (pwm_wrap) begin
          duty_lvl[i] <= current[i];
          duty[i]     <= DW'(UNIT) * DW'(current[i]);
        end
      end
      pending <= (pending & ~pend_clr) | pend_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_valid <= 1'b0;
      status_byte  <= '0;
      cmd_error    <= 1'b0;
    end else begin
      cmd_error <= cmd_take & ~cmd_good;
      if (!status_valid) begin
        if (rpt_hit) begin
          status_valid <= 1'b1;
          status_byte  <= {rpt_ch, 1'b1, rpt_lvl3};
        end
      end else if (status_ready) begin
        status_valid <= 1'b0;
      end
    end
  end

  // Full scale is forced high even when PWM_PERIOD is not a multiple of MAXL.
  always_comb begin
    pwm = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm[i] = (duty_lvl[i] == MAXL) | ((duty_lvl[i] != '0) & (pwm_cnt < duty[i]));
    end
  end

endmodule

// File: tb/tb_pwm_uart_multi.sv
// Bench for pwm_uart_multi: directed scenarios plus random traffic, checked every cycle against a level-based model.
module tb_pwm_uart_multi;
  localparam int CH   = 2;
  localparam int PP   = 14;
  localparam int ST   = 4;
  localparam int MAXL = 7;
`ifdef PWM_UART_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] up = '0;
  logic [1:0] down = '0;
  logic [7:0] cmd_byte = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] status_byte;
  logic       status_valid;
  logic       status_ready = 1'b0;
  logic       cmd_error;
  logic [1:0] pwm;

  pwm_uart_multi #(.CHANNELS(CH), .LEVEL_W(3), .PWM_PERIOD(PP), .STEP_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .status_byte(status_byte), .status_valid(status_valid), .status_ready(status_ready),
    .cmd_error(cmd_error), .pwm(pwm)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0;
  bit sv_seen = 0;

  // Model state: levels per channel, report flags, and the edge count since reset.
  int m_target[CH];
  int m_current[CH];
  int m_lvl[CH];
  bit m_pend[CH];
  bit m_sv = 0;
  int m_sb = 0;
  bit m_err = 0;
  int m_edges = 0;
  bit m_known = 0;
  bit m_accepted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    bit any;
    any = 0;
    for (int i = 0; i < CH; i++) any |= m_pend[i];
    return !any || !m_sv;
  endfunction

  task automatic model_edge();
    int ch, lvl, load_ch;
    bit acc, good, step_now, per_start;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_target[i] = 0; m_current[i] = 0; m_lvl[i] = 0; m_pend[i] = 0;
      end
      m_sv = 0; m_sb = 0; m_err = 0; m_edges = 0; m_known = 1; m_accepted = 0;
    end else begin
      acc  = cmd_valid && m_ready();
      ch   = int'(cmd_byte[7:4]);
      lvl  = int'(cmd_byte[2:0]);
      good = acc && !cmd_byte[3] && (ch < CH);
      load_ch = -1;
      if (!m_sv) begin
        for (int i = CH - 1; i >= 0; i--)
          if (m_pend[i] && m_current[i] == m_target[i]) load_ch = i;
        if (load_ch >= 0) begin
          m_sv = 1;
          m_sb = 16 * load_ch + 8 + m_current[load_ch];
        end
      end else if (status_ready) begin
        m_sv = 0;
      end
      step_now  = RAMP && (m_edges % ST == ST - 1);
      per_start = (m_edges % PP == PP - 1);
      for (int i = 0; i < CH; i++) begin
        if (per_start) m_lvl[i] = m_current[i];
        if (!RAMP) m_current[i] = m_target[i];
        else if (step_now && m_current[i] < m_target[i]) m_current[i]++;
        else if (step_now && m_current[i] > m_target[i]) m_current[i]--;
        if (good && ch == i) m_target[i] = lvl;
        else if (up[i] && !down[i]) m_target[i] = (m_target[i] >= MAXL) ? MAXL : m_target[i] + 1;
        else if (down[i] && !up[i]) m_target[i] = (m_target[i] <= 0) ? 0 : m_target[i] - 1;
        if (load_ch == i) m_pend[i] = 0;
        if (good && ch == i) m_pend[i] = 1;
      end
      m_err = acc && !good;
      m_accepted = acc;
      m_edges++;
    end
  endtask

  task automatic step();
    int exp_pwm, ph;
    model_edge();
    @(posedge clk);
    #1;
    if (m_known) begin
      exp_pwm = 0;
      ph = m_edges % PP;
      for (int i = 0; i < CH; i++)
        if (m_lvl[i] == MAXL || (m_lvl[i] != 0 && ph < m_lvl[i] * (PP / MAXL))) exp_pwm |= (1 << i);
      chk("status_valid", 32'(status_valid), 32'(m_sv));
      chk("status_byte", 32'(status_byte), 32'(m_sb));
      chk("cmd_error", 32'(cmd_error), 32'(m_err));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_ready()));
      chk("pwm", 32'(pwm), 32'(exp_pwm));
    end
    if (status_valid === 1'b1) sv_seen = 1;
    if (cmd_error === 1'b1) err_seen++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int k;
    cmd_byte = b;
    cmd_valid = 1'b1;
    k = 0;
    m_accepted = 0;
    while (!m_accepted && k < 40) begin
      step();
      k++;
    end
    chk("cmd_accept_bound", 32'(m_accepted), 32'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sv(input int bound);
    int k;
    k = 0;
    while (status_valid !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    chk("status_wait", 32'(status_valid), 32'(1));
  endtask

  task automatic ack();
    status_ready = 1'b1;
    step();
    status_ready = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (pwm[ch] === 1'b1) c++;
    end
  endtask

  initial begin
    int c;
    int r;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_status_valid", 32'(status_valid), 32'(0));
    chk("rst_status_byte", 32'(status_byte), 32'(0));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_pwm", 32'(pwm), 32'(0));

    // ch0 ramps to 5
    send_cmd(8'h05);
    wait_sv(100);
    chk("ch0_to5_status", 32'(status_byte), 32'h0D);
    ack();
    run(PP);
    count_high(0, PP, c);
    chk("ch0_lvl5_high", 32'(c), 32'(10));

    // ch1 full scale then off
    send_cmd(8'h17);
    wait_sv(100);
    chk("ch1_to7_status", 32'(status_byte), 32'h1F);
    ack();
    run(PP);
    count_high(1, PP, c);
    chk("ch1_lvl7_high", 32'(c), 32'(PP));
    send_cmd(8'h10);
    wait_sv(100);
    chk("ch1_to0_status", 32'(status_byte), 32'h18);
    ack();
    run(PP);
    count_high(1, PP, c);
    chk("ch1_lvl0_high", 32'(c), 32'(0));

    // malformed commands
    err_seen = 0;
    sv_seen = 0;
    send_cmd(8'h23);
    send_cmd(8'h0B);
    run(20);
    chk("bad_cmd_errors", 32'(err_seen), 32'(2));
    chk("bad_cmd_no_status", 32'(sv_seen), 32'(0));
    count_high(0, PP, c);
    chk("bad_cmd_ch0_kept", 32'(c), 32'(10));

    // simultaneous arrival, held handshake
    send_cmd(8'h00);
    wait_sv(100);
    ack();
    send_cmd(8'h03);
    send_cmd(8'h13);
    wait_sv(100);
    chk("pair_first", 32'(status_byte), 32'h0B);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pair_hold_byte", 32'(status_byte), 32'h0B);
      chk("pair_hold_valid", 32'(status_valid), 32'(1));
    end
    ack();
    wait_sv(20);
    chk("pair_second", 32'(status_byte), 32'h1B);
    ack();

    // button saturation, no report from buttons
    send_cmd(8'h06);
    wait_sv(100);
    ack();
    sv_seen = 0;
    for (int k = 0; k < 5; k++) begin
      up = 2'b01;
      step();
      up = 2'b00;
      step();
    end
    run(40);
    chk("btn_no_status", 32'(sv_seen), 32'(0));
    count_high(0, PP, c);
    chk("btn_sat_high", 32'(c), 32'(PP));
    up = 2'b01;
    down = 2'b01;
    step();
    up = 2'b00;
    down = 2'b00;
    run(30);
    count_high(0, PP, c);
    chk("btn_both_ignored", 32'(c), 32'(PP));

    // random traffic
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom);
      up   = (r % 6 == 0) ? 2'($urandom) : 2'b00;
      down = (r % 7 == 0) ? 2'($urandom) : 2'b00;
      cmd_valid = ($urandom % 4 == 0);
      cmd_byte = 8'(16 * $urandom_range(0, 2) + (($urandom % 8 == 0) ? 8 : 0) + $urandom_range(0, 7));
      status_ready = ($urandom % 3 != 0);
      step();
    end
    up = '0;
    down = '0;
    cmd_valid = 1'b0;
    status_ready = 1'b0;

    // reset mid-ramp with a report held
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_cmd(8'h01);
    send_cmd(8'h17);
    wait_sv(40);
    chk("midrst_held", 32'(status_byte), 32'h09);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_status_valid", 32'(status_valid), 32'(0));
    chk("midrst_status_byte", 32'(status_byte), 32'(0));
    chk("midrst_cmd_error", 32'(cmd_error), 32'(0));
    chk("midrst_pwm", 32'(pwm), 32'(0));
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    sv_seen = 0;
    run(40);
    chk("midrst_report_dropped", 32'(sv_seen), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
